byte_unstriping_rx: RTL and testbench

- Receive-side counterpart of the 4-lane byte striper.
- Collects bytes arriving on 4 parallel lanes and reassembles them into a single byte stream, in strict lane order 0,1,2,3,0,...
- Each lane has a small FIFO that absorbs inter-lane skew.
- Sits between the lane PHY/deskew logic and the byte-stream consumer in the receive path.

---
 rtl/byte_unstriping_rx_pkg.sv | 25 ++
 rtl/byte_unstriping_rx_if.sv | 36 +++
 rtl/byte_unstriping_rx_lane_fifo.sv | 50 +++++
 rtl/byte_unstriping_rx.sv | 89 ++++++++
 tb/tb_byte_unstriping_rx.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/byte_unstriping_rx_pkg.sv
// rtl/byte_unstriping_rx_pkg.sv - shared constants and types for the 4-lane byte unstriper
package unstripe_pkg;

  localparam int NUM_LANES          = 4;
  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef logic [1:0] lane_idx_t;

  // One read state per lane; the encoding doubles as the rd_lane status value.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } rd_state_t;

  // Strict round-robin order; S3 wraps back to S0.
  function automatic rd_state_t next_state(input rd_state_t s);
    lane_idx_t n;
    n = lane_idx_t'(s) + 2'd1;
    return rd_state_t'(n);
  endfunction

endpackage

// File: rtl/byte_unstriping_rx_if.sv
// rtl/byte_unstriping_rx_if.sv - lane inputs and reassembled stream outputs (UNSTRIPE_BYTE_CNT_EN adds byte_cnt)
interface byte_unstriping_rx_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        lane_valid;
  logic [DATA_W-1:0] lane_data0;
  logic [DATA_W-1:0] lane_data1;
  logic [DATA_W-1:0] lane_data2;
  logic [DATA_W-1:0] lane_data3;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [3:0]        overflow;
  logic [1:0]        rd_lane;
`ifdef UNSTRIPE_BYTE_CNT_EN
  logic [15:0]       byte_cnt;
`endif

  // Lane/PHY side drives the lanes and observes the stream.
  modport master (
    output lane_valid, lane_data0, lane_data1, lane_data2, lane_data3,
    input  data_out, valid_out, overflow, rd_lane
`ifdef UNSTRIPE_BYTE_CNT_EN
    , input byte_cnt
`endif
  );

  // The unstriper itself.
  modport slave (
    input  lane_valid, lane_data0, lane_data1, lane_data2, lane_data3,
    output data_out, valid_out, overflow, rd_lane
`ifdef UNSTRIPE_BYTE_CNT_EN
    , output byte_cnt
`endif
  );

endinterface

// File: rtl/byte_unstriping_rx_lane_fifo.sv
// rtl/byte_unstriping_rx_lane_fifo.sv - per-lane skew FIFO with wrap-bit pointers and combinational head
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4   // power of 2, at least 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on a full FIFO frees the head slot at the same edge, so the push may proceed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  // Pointer update; natural wrap modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/byte_unstriping_rx.sv
// rtl/byte_unstriping_rx.sv - 4-lane byte unstriper top: lane FIFOs, round-robin read FSM, overflow flags (optional UNSTRIPE_BYTE_CNT_EN byte counter)
module byte_unstriping_rx
  import unstripe_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_unstriping_rx_if.slave  bus
);

  logic [DATA_W-1:0]    lane_data [NUM_LANES];
  logic [DATA_W-1:0]    head      [NUM_LANES];
  logic [NUM_LANES-1:0] empty;
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] pop;

  rd_state_t            state;
  logic [DATA_W-1:0]    data_q;
  logic                 valid_q;
  logic [NUM_LANES-1:0] overflow_q;
`ifdef UNSTRIPE_BYTE_CNT_EN
  logic [15:0]          byte_cnt_q;
`endif

  assign lane_data[0] = bus.lane_data0;
  assign lane_data[1] = bus.lane_data1;
  assign lane_data[2] = bus.lane_data2;
  assign lane_data[3] = bus.lane_data3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.lane_valid[i]),
      .pop   (pop[i]),
      .din   (lane_data[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // Only the lane selected by the FSM may pop, and only when it has data.
  always_comb begin
    pop        = '0;
    pop[state] = !empty[state];
  end

  // Read FSM with registered stream outputs, sticky drop flags and optional byte count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= '0;
`ifdef UNSTRIPE_BYTE_CNT_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      // A byte is dropped only when its FIFO is full and not being drained this edge.
      overflow_q <= overflow_q | (bus.lane_valid & full & ~pop);
      if (pop[state]) begin
        data_q  <= head[state];
        valid_q <= 1'b1;
        state   <= next_state(state);
`ifdef UNSTRIPE_BYTE_CNT_EN
        byte_cnt_q <= byte_cnt_q + 16'd1;
`endif
      end else begin
        // Wait on the skewed lane; never skip it, keep the last byte on data_out.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.rd_lane   = state;
`ifdef UNSTRIPE_BYTE_CNT_EN
  assign bus.byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_byte_unstriping_rx.sv
// tb/tb_byte_unstriping_rx.sv - directed self-checking bench for byte_unstriping_rx
module tb_byte_unstriping_rx;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  byte_unstriping_rx_if #(.DATA_W(8)) bus ();

  byte_unstriping_rx #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    bus.lane_valid = v;
    bus.lane_data0 = d0;
    bus.lane_data1 = d1;
    bus.lane_data2 = d2;
    bus.lane_data3 = d3;
  endtask

  task automatic idle();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  // Checks stream outputs right after an edge.
  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] lane);
    check({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, v});
    if (v) check({tag, ".data"}, {24'd0, bus.data_out}, {24'd0, d});
    check({tag, ".rd_lane"}, {30'd0, bus.rd_lane}, {30'd0, lane});
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, ".valid"},    {31'd0, bus.valid_out}, 32'd0);
    check({tag, ".data"},     {24'd0, bus.data_out},  32'd0);
    check({tag, ".rd_lane"},  {30'd0, bus.rd_lane},   32'd0);
    check({tag, ".overflow"}, {28'd0, bus.overflow},  32'd0);
`ifdef UNSTRIPE_BYTE_CNT_EN
    check({tag, ".byte_cnt"}, {16'd0, bus.byte_cnt},  32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] wexp [12];

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    idle();
    #12;
    check("rst.valid",    {31'd0, bus.valid_out}, 32'd0);
    check("rst.data",     {24'd0, bus.data_out},  32'd0);
    check("rst.overflow", {28'd0, bus.overflow},  32'd0);
    check("rst.rd_lane",  {30'd0, bus.rd_lane},   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Aligned word: push at E, bytes emerge on E+1..E+4.
    drive(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    tick();
    idle();
    expect_out("al.e0", 1'b0, 8'h00, 2'd0);
    tick(); expect_out("al.b0", 1'b1, 8'hA0, 2'd1);
    tick(); expect_out("al.b1", 1'b1, 8'hA1, 2'd2);
    tick(); expect_out("al.b2", 1'b1, 8'hA2, 2'd3);
    tick(); expect_out("al.b3", 1'b1, 8'hA3, 2'd0);
    tick(); expect_out("al.end", 1'b0, 8'h00, 2'd0);
    check("al.data_hold", {24'd0, bus.data_out}, 32'hA3);

    // Skew: lane 2 arrives three edges late; FSM stalls on it without skipping.
    drive(4'b1011, 8'hB0, 8'hB1, 8'h00, 8'hB3);
    tick();
    idle();
    tick(); expect_out("sk.b0", 1'b1, 8'hB0, 2'd1);
    tick(); expect_out("sk.b1", 1'b1, 8'hB1, 2'd2);
    drive(4'b0100, 8'h00, 8'h00, 8'hB2, 8'h00);
    tick(); expect_out("sk.stall", 1'b0, 8'h00, 2'd2);
    idle();
    tick(); expect_out("sk.b2", 1'b1, 8'hB2, 2'd3);
    tick(); expect_out("sk.b3", 1'b1, 8'hB3, 2'd0);
    check("sk.overflow", {28'd0, bus.overflow}, 32'd0);

    // Wrap-around: three aligned words back-to-back; FIFO pointers pass the index wrap.
    for (int w = 0; w < 3; w++)
      for (int l = 0; l < 4; l++)
        wexp[w*4+l] = 8'h50 + 8'(w*4 + l);
    for (int c = 0; c < 14; c++) begin
      if (c < 3)
        drive(4'hF, wexp[c*4], wexp[c*4+1], wexp[c*4+2], wexp[c*4+3]);
      else
        idle();
      tick();
      if (c >= 1 && c <= 12)
        expect_out($sformatf("wr.c%0d", c), 1'b1, wexp[c-1], 2'(c));
      else
        check($sformatf("wr.c%0d.valid", c), {31'd0, bus.valid_out}, 32'd0);
    end
    check("wr.overflow", {28'd0, bus.overflow}, 32'd0);

    // Overflow: only lane 0 pushes; C0 drains, then C1..C4 fill the FIFO and C5 drops.
    for (int c = 0; c < 6; c++) begin
      drive(4'b0001, 8'hC0 + 8'(c), 8'h00, 8'h00, 8'h00);
      tick();
      if (c == 1) expect_out("ov.c0", 1'b1, 8'hC0, 2'd1);
      if (c >= 2) expect_out($sformatf("ov.stall%0d", c), 1'b0, 8'h00, 2'd1);
      if (c == 4) check("ov.before", {28'd0, bus.overflow}, 32'd0);
    end
    idle();
    check("ov.set", {28'd0, bus.overflow}, 32'h1);
    tick(); tick();
    check("ov.sticky", {28'd0, bus.overflow}, 32'h1);
    expect_out("ov.still", 1'b0, 8'h00, 2'd1);
    async_reset("ov.rst");
    tick(); tick();
    check("ov.flushed", {31'd0, bus.valid_out}, 32'd0);

    // Reset mid-stream after two of four bytes, then a fresh word starts at lane 0.
    drive(4'hF, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    tick();
    idle();
    tick(); expect_out("mr.e0", 1'b1, 8'hE0, 2'd1);
    tick(); expect_out("mr.e1", 1'b1, 8'hE1, 2'd2);
    async_reset("mr.rst");
    drive(4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    tick();
    idle();
    tick(); expect_out("mr.d0", 1'b1, 8'hD0, 2'd1);
    tick(); expect_out("mr.d1", 1'b1, 8'hD1, 2'd2);
    tick(); expect_out("mr.d2", 1'b1, 8'hD2, 2'd3);
    tick(); expect_out("mr.d3", 1'b1, 8'hD3, 2'd0);
    tick(); expect_out("mr.end", 1'b0, 8'h00, 2'd0);

`ifdef UNSTRIPE_BYTE_CNT_EN
    check("bc.four", {16'd0, bus.byte_cnt}, 32'd4);
    async_reset("bc.rst");
    // Rotate one lane per cycle so exactly one byte is produced per cycle.
    for (int c = 0; c < 32'h10001; c++) begin
      bus.lane_valid = 4'(1 << (c % 4));
      bus.lane_data0 = 8'(c);
      bus.lane_data1 = 8'(c);
      bus.lane_data2 = 8'(c);
      bus.lane_data3 = 8'(c);
      tick();
    end
    idle();
    tick(); tick(); tick();
    check("bc.wrap", {16'd0, bus.byte_cnt}, 32'h1);
    check("bc.overflow", {28'd0, bus.overflow}, 32'd0);
    check("bc.rd_lane", {30'd0, bus.rd_lane}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
